// File: rtl/ghost_mode_scheduler.sv
// rtl/ghost_mode_scheduler.sv - scatter/chase phase timer, fright timer and per-ghost state FSMs
// Optional flash output enabled with GHOST_FLASH_EN.
module ghost_mode_scheduler #(
  parameter int SCATTER_FRAMES = 420,
  parameter int CHASE_FRAMES   = 1200,
  parameter int NUM_SCATTER    = 4,
  parameter int FRIGHT_FRAMES  = 360,
  parameter int FLASH_FRAMES   = 120
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_frame_tick,
  input  logic       i_enable,
  input  logic       i_start,
  input  logic       i_power_pellet,
  input  logic [3:0] i_release,
  input  logic [3:0] i_ghost_eaten,
  input  logic [3:0] i_ghost_home,
  output logic [3:0] o_blinky_state,
  output logic [3:0] o_pinky_state,
  output logic [3:0] o_inky_state,
  output logic [3:0] o_clyde_state,
  output logic       o_global_chase,
  output logic       o_fright_active,
  output logic       o_fright_flash,
  output logic [3:0] o_reverse
);

  localparam logic [3:0] G_IDLE       = 4'd0;
  localparam logic [3:0] G_SCATTER    = 4'd1;
  localparam logic [3:0] G_CHASE      = 4'd2;
  localparam logic [3:0] G_FRIGHTENED = 4'd3;
  localparam logic [3:0] G_DIE        = 4'd4;

  localparam int PMAX  = 2 * NUM_SCATTER;
  localparam int PW    = $clog2(PMAX + 1);
  localparam int CMAX  = (SCATTER_FRAMES > CHASE_FRAMES) ? SCATTER_FRAMES : CHASE_FRAMES;
  localparam int CW    = $clog2(CMAX + 1);
  localparam int FW    = $clog2(FRIGHT_FRAMES + 1);

  logic [PW-1:0]     phase_q, phase_d;
  logic [CW-1:0]     pcnt_q, pcnt_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic [3:0][3:0]   gst_q, gst_d;
  logic              chase_q, chase_d;
  logic              fact_q, fact_d;
  logic              flash_q, flash_d;
  logic [3:0]        rev_q, rev_d;
  logic              phase_chg, fexp;
  logic [3:0]        gm_d;

  function automatic logic is_run(input logic [3:0] s);
    return (s == G_SCATTER) || (s == G_CHASE);
  endfunction

  always_comb begin
    phase_d   = phase_q;
    pcnt_d    = pcnt_q;
    phase_chg = 1'b0;
    // The final phase is a permanent chase, so its counter is simply frozen.
    if (i_frame_tick && i_enable && !fact_q && (phase_q != PW'(PMAX))) begin
      if (pcnt_q == CW'(1)) begin
        phase_d   = phase_q + PW'(1);
        pcnt_d    = phase_d[0] ? CW'(CHASE_FRAMES) : CW'(SCATTER_FRAMES);
        phase_chg = 1'b1;
      end else begin
        pcnt_d = pcnt_q - CW'(1);
      end
    end
    chase_d = phase_d[0] || (phase_d == PW'(PMAX));
    gm_d    = chase_d ? G_CHASE : G_SCATTER;

    fcnt_d = fcnt_q;
    fexp   = 1'b0;
    if (i_power_pellet) begin
      fcnt_d = FW'(FRIGHT_FRAMES);
    end else if (i_frame_tick && i_enable && fact_q) begin
      fcnt_d = fcnt_q - FW'(1);
      fexp   = (fcnt_q == FW'(1));
    end
    fact_d = (fcnt_d != '0);
`ifdef GHOST_FLASH_EN
    flash_d = fact_d && (fcnt_d <= FW'(FLASH_FRAMES));
`else
    flash_d = 1'b0;
`endif

    // Released ghosts take the mode that becomes current on this edge so they never lag a phase change.
    for (int g = 0; g < 4; g++) begin
      gst_d[g] = gst_q[g];
      rev_d[g] = 1'b0;
      if (gst_q[g] == G_FRIGHTENED && i_ghost_eaten[g]) begin
        gst_d[g] = G_DIE;
      end else if (i_power_pellet && (is_run(gst_q[g]) || gst_q[g] == G_FRIGHTENED)) begin
        gst_d[g] = G_FRIGHTENED;
        rev_d[g] = is_run(gst_q[g]);
      end else if (fexp && gst_q[g] == G_FRIGHTENED) begin
        gst_d[g] = gm_d;
      end else if (phase_chg && is_run(gst_q[g])) begin
        gst_d[g] = gm_d;
        rev_d[g] = 1'b1;
      end else if (gst_q[g] == G_IDLE && i_release[g]) begin
        gst_d[g] = gm_d;
      end else if (gst_q[g] == G_DIE && i_ghost_home[g]) begin
        gst_d[g] = G_IDLE;
      end
    end

    if (i_start) begin
      phase_d = '0;
      pcnt_d  = CW'(SCATTER_FRAMES);
      chase_d = 1'b0;
      fcnt_d  = '0;
      fact_d  = 1'b0;
      flash_d = 1'b0;
      gst_d   = {4{G_IDLE}};
      rev_d   = 4'b0000;
    end
  end

`ifndef GHOST_FLASH_EN
  logic unused_flash;
  assign unused_flash = (FLASH_FRAMES > FRIGHT_FRAMES);
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      phase_q <= '0;
      pcnt_q  <= CW'(SCATTER_FRAMES);
      fcnt_q  <= '0;
      gst_q   <= {4{G_IDLE}};
      chase_q <= 1'b0;
      fact_q  <= 1'b0;
      flash_q <= 1'b0;
      rev_q   <= 4'b0000;
    end else begin
      phase_q <= phase_d;
      pcnt_q  <= pcnt_d;
      fcnt_q  <= fcnt_d;
      gst_q   <= gst_d;
      chase_q <= chase_d;
      fact_q  <= fact_d;
      flash_q <= flash_d;
      rev_q   <= rev_d;
    end
  end

  assign o_blinky_state  = gst_q[0];
  assign o_pinky_state   = gst_q[1];
  assign o_inky_state    = gst_q[2];
  assign o_clyde_state   = gst_q[3];
  assign o_global_chase  = chase_q;
  assign o_fright_active = fact_q;
  assign o_fright_flash  = flash_q;
  assign o_reverse       = rev_q;

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// tb/tb_ghost_mode_scheduler.sv - directed and random checks of ghost_mode_scheduler against a behavioural model
module tb_ghost_mode_scheduler;
  localparam int S  = 4;
  localparam int C  = 6;
  localparam int NS = 2;
  localparam int FR = 5;
  localparam int FL = 2;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_frame_tick = 1'b0;
  logic       i_enable = 1'b1;
  logic       i_start = 1'b0;
  logic       i_power_pellet = 1'b0;
  logic [3:0] i_release = '0;
  logic [3:0] i_ghost_eaten = '0;
  logic [3:0] i_ghost_home = '0;
  logic [3:0] o_blinky_state, o_pinky_state, o_inky_state, o_clyde_state;
  logic       o_global_chase, o_fright_active, o_fright_flash;
  logic [3:0] o_reverse;

  ghost_mode_scheduler #(
    .SCATTER_FRAMES(S), .CHASE_FRAMES(C), .NUM_SCATTER(NS),
    .FRIGHT_FRAMES(FR), .FLASH_FRAMES(FL)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_frame_tick(i_frame_tick), .i_enable(i_enable),
    .i_start(i_start), .i_power_pellet(i_power_pellet), .i_release(i_release),
    .i_ghost_eaten(i_ghost_eaten), .i_ghost_home(i_ghost_home),
    .o_blinky_state(o_blinky_state), .o_pinky_state(o_pinky_state),
    .o_inky_state(o_inky_state), .o_clyde_state(o_clyde_state),
    .o_global_chase(o_global_chase), .o_fright_active(o_fright_active),
    .o_fright_flash(o_fright_flash), .o_reverse(o_reverse)
  );

  always #5 i_clk = ~i_clk;

  localparam int IDLE = 0, SCAT = 1, CHAS = 2, FRIT = 3, DIE = 4;

  int checks = 0;
  int errors = 0;

  // Model: phase index, ticks left in phase, fright ticks left, ghost modes.
  int m_p, m_left, m_fr;
  int m_g[4];
  int m_rev[4];

  function automatic int mode_of(input int p);
    return ((p % 2) == 1 || p == 2 * NS) ? CHAS : SCAT;
  endfunction

  function automatic int len_of(input int p);
    return ((p % 2) == 1) ? C : S;
  endfunction

  task automatic model_step();
    bit chg, expire;
    int gm;
    for (int g = 0; g < 4; g++) m_rev[g] = 0;
    if (!i_rst_n || i_start) begin
      m_p = 0; m_left = S; m_fr = 0;
      for (int g = 0; g < 4; g++) m_g[g] = IDLE;
      return;
    end
    chg = 0; expire = 0;
    if (i_frame_tick && i_enable && m_fr == 0 && m_p < 2 * NS) begin
      m_left--;
      if (m_left == 0) begin
        m_p++;
        m_left = len_of(m_p);
        chg = 1;
      end
    end
    if (i_power_pellet) m_fr = FR;
    else if (i_frame_tick && i_enable && m_fr > 0) begin
      m_fr--;
      expire = (m_fr == 0);
    end
    gm = mode_of(m_p);
    for (int g = 0; g < 4; g++) begin
      bit run;
      run = (m_g[g] == SCAT || m_g[g] == CHAS);
      if (m_g[g] == FRIT && i_ghost_eaten[g]) m_g[g] = DIE;
      else if (i_power_pellet && (run || m_g[g] == FRIT)) begin
        m_g[g] = FRIT; m_rev[g] = run ? 1 : 0;
      end else if (expire && m_g[g] == FRIT) m_g[g] = gm;
      else if (chg && run) begin
        m_g[g] = gm; m_rev[g] = 1;
      end else if (m_g[g] == IDLE && i_release[g]) m_g[g] = gm;
      else if (m_g[g] == DIE && i_ghost_home[g]) m_g[g] = IDLE;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    int rv, fl;
    rv = m_rev[0] + 2 * m_rev[1] + 4 * m_rev[2] + 8 * m_rev[3];
`ifdef GHOST_FLASH_EN
    fl = (m_fr > 0 && m_fr <= FL) ? 1 : 0;
`else
    fl = 0;
`endif
    check("blinky", int'(o_blinky_state), m_g[0]);
    check("pinky", int'(o_pinky_state), m_g[1]);
    check("inky", int'(o_inky_state), m_g[2]);
    check("clyde", int'(o_clyde_state), m_g[3]);
    check("global_chase", int'(o_global_chase), (mode_of(m_p) == CHAS) ? 1 : 0);
    check("fright_active", int'(o_fright_active), (m_fr > 0) ? 1 : 0);
    check("fright_flash", int'(o_fright_flash), fl);
    check("reverse", int'(o_reverse), rv);
  endtask

  task automatic cyc();
    @(posedge i_clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic pulse_start();
    i_start = 1'b1; cyc(); i_start = 1'b0;
  endtask

  task automatic rel(input logic [3:0] m);
    i_release = m; cyc(); i_release = '0;
  endtask

  task automatic pellet();
    i_power_pellet = 1'b1; cyc(); i_power_pellet = 1'b0;
  endtask

  task automatic ticks(input int n);
    i_frame_tick = 1'b1;
    repeat (n) cyc();
    i_frame_tick = 1'b0;
  endtask

  initial begin
    // Reset state
    i_rst_n = 1'b0; cyc(); cyc();
    check("pin_reset_blinky", int'(o_blinky_state), IDLE);
    check("pin_reset_chase", int'(o_global_chase), 0);
    i_rst_n = 1'b1;

    // Full phase sequence
    pulse_start(); rel(4'b1111);
    check("pin_released", int'(o_clyde_state), SCAT);
    ticks(3);
    check("pin_scatter_3", int'(o_inky_state), SCAT);
    ticks(1);
    check("pin_chase_4", int'(o_pinky_state), CHAS);
    check("pin_rev_all", int'(o_reverse), 4'b1111);
    cyc();
    check("pin_rev_clear", int'(o_reverse), 0);
    ticks(6);
    check("pin_scatter2", int'(o_blinky_state), SCAT);
    ticks(4);
    check("pin_chase2", int'(o_blinky_state), CHAS);
    ticks(100);
    check("pin_chase_perm", int'(o_clyde_state), CHAS);
    check("pin_chase_perm_g", int'(o_global_chase), 1);

    // Fright on blinky only
    pulse_start(); rel(4'b0001); pellet();
    check("pin_fright", int'(o_blinky_state), FRIT);
    check("pin_fright_rev", int'(o_reverse), 4'b0001);
    check("pin_pinky_idle", int'(o_pinky_state), IDLE);
    ticks(2);
    check("pin_noflash_2", int'(o_fright_flash), 0);
    ticks(1);
`ifdef GHOST_FLASH_EN
    check("pin_flash_3", int'(o_fright_flash), 1);
`endif
    ticks(2);
    check("pin_fright_end", int'(o_blinky_state), SCAT);
    check("pin_fright_off", int'(o_fright_active), 0);

    // Eaten then home; eaten on a chasing ghost ignored
    pellet();
    i_ghost_eaten = 4'b0001; cyc(); i_ghost_eaten = '0;
    check("pin_die", int'(o_blinky_state), DIE);
    i_ghost_home = 4'b0001; cyc(); i_ghost_home = '0;
    check("pin_home", int'(o_blinky_state), IDLE);
    ticks(5);
    rel(4'b0010); ticks(4);
    check("pin_pinky_chase", int'(o_pinky_state), CHAS);
    i_ghost_eaten = 4'b0010; cyc(); i_ghost_eaten = '0;
    check("pin_eat_ignored", int'(o_pinky_state), CHAS);

    // Pellet + eaten same cycle, phase frozen during fright
    pulse_start(); rel(4'b0001); ticks(2); pellet(); ticks(4);
    i_power_pellet = 1'b1; i_ghost_eaten = 4'b0001; cyc();
    i_power_pellet = 1'b0; i_ghost_eaten = '0;
    check("pin_pe_die", int'(o_blinky_state), DIE);
    check("pin_pe_active", int'(o_fright_active), 1);
    ticks(4);
    check("pin_pe_still", int'(o_fright_active), 1);
    ticks(1);
    check("pin_pe_done", int'(o_fright_active), 0);
    i_ghost_home = 4'b0001; cyc(); i_ghost_home = '0;
    rel(4'b0001); ticks(1);
    check("pin_frozen_scat", int'(o_global_chase), 0);
    ticks(1);
    check("pin_frozen_chase", int'(o_blinky_state), CHAS);

    // Disabled ticks, start mid-fright, reset mid-chase
    pulse_start(); rel(4'b1111);
    i_enable = 1'b0; ticks(20); i_enable = 1'b1;
    check("pin_disabled", int'(o_inky_state), SCAT);
    ticks(4); pellet(); ticks(1); pulse_start();
    check("pin_start_idle", int'(o_blinky_state), IDLE);
    check("pin_start_fright", int'(o_fright_active), 0);
    check("pin_start_chase", int'(o_global_chase), 0);
    rel(4'b1111); ticks(4);
    i_rst_n = 1'b0; cyc(); i_rst_n = 1'b1;
    check("pin_rst_chase", int'(o_global_chase), 0);
    check("pin_rst_state", int'(o_clyde_state), IDLE);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      i_rst_n        = ($urandom_range(0, 499) != 0);
      i_start        = ($urandom_range(0, 299) == 0);
      i_enable       = ($urandom_range(0, 9) != 0);
      i_frame_tick   = $urandom_range(0, 1);
      i_power_pellet = ($urandom_range(0, 39) == 0);
      for (int g = 0; g < 4; g++) begin
        i_release[g]     = ($urandom_range(0, 9) == 0);
        i_ghost_eaten[g] = ($urandom_range(0, 9) == 0);
        i_ghost_home[g]  = ($urandom_range(0, 4) == 0);
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ghost_mode_scheduler.md
# ghost_mode_scheduler

Sequences the per-ghost behaviour states (G_IDLE, G_SCATTER, G_CHASE, G_FRIGHTENED, G_DIE from params.vh) for blinky, pinky, inky and clyde. It runs the global scatter/chase phase timer and the power-pellet frightened timer, and steps each ghost's state machine on game events. Its four state outputs feed the ghost movement logic and the ghost sprite pose selection.

## Interface
- SCATTER_FRAMES, 420, frame ticks per scatter phase
- CHASE_FRAMES, 1200, frame ticks per chase phase (non-final)
- NUM_SCATTER, 4, scatter phases per level; chase is permanent after the last one
- FRIGHT_FRAMES, 360, frame ticks of frightened mode
- FLASH_FRAMES, 120, final fright ticks with flash asserted; must be ≤ FRIGHT_FRAMES
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_frame_tick  in  1  one-cycle pulse per video frame
- i_enable  in  1  timers advance only when high (pause/death animation)
- i_start  in  1  pulse; level (re)start
- i_power_pellet  in  1  pulse; pac-man ate a power pellet
- i_release  in  4  per-ghost pulse (bit0 blinky, 1 pinky, 2 inky, 3 clyde); ghost leaves house
- i_ghost_eaten  in  4  per-ghost pulse; pac-man collided with ghost
- i_ghost_home  in  4  per-ghost level; ghost sits on house entry tile
- o_blinky_state, o_pinky_state, o_inky_state, o_clyde_state  out  4  ghost state (G_* encoding)
- o_global_chase  out  1  0 = scatter phase, 1 = chase phase
- o_fright_active  out  1  fright timer running
- o_fright_flash  out  1  fright remaining ≤ FLASH_FRAMES
- o_reverse  out  4  per-ghost one-cycle pulse: reverse direction

## Operation
- Global phase: phase index p in 0..2·NUM_SCATTER. Even p = scatter (SCATTER_FRAMES), odd p = chase (CHASE_FRAMES). p = 2·NUM_SCATTER is chase, never expires.
- Phase counter: down-counter with width $clog2(max+1), loaded on entry. It decrements on `i_frame_tick & i_enable & !fright_active`. On the tick that takes it from 1 to 0, p increments and the counter reloads. Each phase therefore lasts exactly N qualifying ticks.
- Fright counter: loaded with FRIGHT_FRAMES on i_power_pellet, including when already active (restart). It decrements on `i_frame_tick & i_enable`. The tick that takes it from 1 to 0 ends fright. While fright is active the global phase is frozen.
- Per-ghost FSM, where GM = G_CHASE if o_global_chase else G_SCATTER:
  - IDLE → GM on its i_release bit. Fright never applies to IDLE ghosts.
  - SCATTER/CHASE → follows GM when the phase changes.
  - SCATTER/CHASE/FRIGHTENED → FRIGHTENED on i_power_pellet.
  - FRIGHTENED → DIE on its i_ghost_eaten bit.
  - FRIGHTENED → GM on fright expiry.
  - DIE → IDLE when its i_ghost_home bit is high.
- Ignored events: eaten when not FRIGHTENED, home when not DIE, release when not IDLE.
- Priority, highest first: reset > i_start > eaten > pellet > fright expiry > phase change. A pellet and an eaten pulse on the same ghost in the same cycle → DIE, and the timer still reloads. A pellet on the expiry cycle → fright continues, reloaded.
- o_reverse[g] pulses when ghost g is SCATTER/CHASE at a phase change, or enters FRIGHTENED from SCATTER/CHASE. There is no pulse on FRIGHTENED → FRIGHTENED.
- i_start: all ghosts IDLE, p = 0, phase counter = SCATTER_FRAMES, fright cleared, o_reverse = 0.

## Timing
- All outputs are registered. An input event sampled at edge n is visible after edge n (next cycle); latency is 1 cycle.
- Reset values: all ghost states G_IDLE, o_global_chase 0, o_fright_active 0, o_fright_flash 0, o_reverse 0, p = 0, phase counter SCATTER_FRAMES, fright counter 0.
- An i_frame_tick with i_enable low has no effect on either counter.
- o_fright_flash is high in the same cycles that o_fright_active is high and the fright counter is ≤ FLASH_FRAMES.

## Configuration
- GHOST_FLASH_EN defined: o_fright_flash behaves as specified above.
- GHOST_FLASH_EN undefined: o_fright_flash is tied to 0, and the flash compare logic and FLASH_FRAMES are unused.

## Test plan
All scenarios use SCATTER_FRAMES=4, CHASE_FRAMES=6, NUM_SCATTER=2, FRIGHT_FRAMES=5, FLASH_FRAMES=2, GHOST_FLASH_EN defined.

- Reset, i_start, release all ghosts, 4 enabled ticks → all states G_SCATTER until the 4th tick; then G_CHASE with o_reverse=4'b1111 for one cycle. After 6 more ticks → G_SCATTER. After 4 more → G_CHASE permanently: 100 further ticks cause no change.
- Release blinky only, then pellet → blinky G_FRIGHTENED with o_reverse=4'b0001; others remain G_IDLE. On the 3rd tick o_fright_flash=1. On the 5th tick blinky returns to GM and o_fright_active=0.
- During fright pulse i_ghost_eaten=4'b0001 → blinky G_DIE. Hold i_ghost_home[0]=1 → G_IDLE next cycle. An eaten pulse on a G_CHASE ghost is ignored.
- Pellet at fright tick 4, then a pellet plus eaten[0] in the same cycle → fright reloaded to 5 and blinky G_DIE. The phase counter does not advance during fright; with 2 scatter ticks already elapsed, G_CHASE arrives 2 ticks after fright ends.
- i_enable=0 with 20 ticks → no state change. i_start mid-fright → all G_IDLE, o_fright_active=0, o_global_chase=0. i_rst_n=0 mid-chase → all outputs at reset values next cycle.
